// File: rtl/req_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// master = requester/resource side, slave = arbiter side.
interface req_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = 4
);
  logic [NUM_REQ-1:0]   req;
  logic                 done;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_valid;
  logic [SEL_WIDTH-1:0] sel;
  logic                 timeout;
  logic                 busy;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  sel,
    input  timeout,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output sel,
    output timeout,
    output busy
  );
endinterface

// File: rtl/req_arbiter.sv
// Round-robin arbiter for one shared datapath resource.
// Holds a grant until done, abandon or hold timeout; one idle gap between grants.
module req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = 4,
  parameter int MAX_HOLD  = 64
) (
  input logic          clk,
  input logic          rst,
  req_arbiter_if.slave arb
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num
    $error("req_arbiter: NUM_REQ out of range");
  end
  if ((1 << SEL_WIDTH) < NUM_REQ) begin : g_bad_sel
    $error("req_arbiter: SEL_WIDTH too narrow");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;

  logic [NUM_REQ-1:0]   hi_oh, lo_oh, win_oh;
  logic [SEL_WIDTH-1:0] hi_idx, lo_idx, win_idx;
  logic                 hi_hit, lo_hit;
  logic                 own_req;
  logic                 hold_hit;
  logic                 release_now;

  // Rotating search: first hit at or above ptr, else first hit overall.
  always_comb begin
    hi_oh  = '0;
    lo_oh  = '0;
    hi_idx = '0;
    lo_idx = '0;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb.req[i] && !lo_hit) begin
        lo_hit   = 1'b1;
        lo_idx   = SEL_WIDTH'(i);
        lo_oh[i] = 1'b1;
      end
      if (arb.req[i] && !hi_hit &&
          SEL_WIDTH'(i) >= ptr_q) begin
        hi_hit   = 1'b1;
        hi_idx   = SEL_WIDTH'(i);
        hi_oh[i] = 1'b1;
      end
    end
  end

  assign win_oh  = hi_hit ? hi_oh : lo_oh;
  assign win_idx = hi_hit ? hi_idx : lo_idx;

  assign own_req  = |(gnt_q & arb.req);
  assign hold_hit = HOLD_EN && (cnt_q == CNT_LAST);
  assign release_now = arb.done || !own_req || hold_hit;

  // Next-state and next-output logic; release causes checked done first.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lo_hit) begin
          state_d = S_BUSY;
          gnt_d   = win_oh;
          sel_d   = win_idx;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (HOLD_EN && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (release_now) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = (sel_q == LAST_IDX) ? '0
                                         : sel_q + 1'b1;
          tmo_d   = !arb.done && own_req && hold_hit;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.sel       = sel_q;
  assign arb.timeout   = tmo_q;
  assign arb.busy      = (state_q == S_BUSY);
  assign arb.gnt_valid = (state_q == S_BUSY);

endmodule
